// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg
//   Shared definitions for the Ethernet receive path: the framer FSM state
//   encoding, the preamble/SFD line symbols for RMII (2-bit) and MII (4-bit)
//   PHYs, and the CRC-32 constants used by the framer and a future TX block.
//   No ports; import with eth_rx_pkg::*.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_t;

  // Preamble byte 0x55 and SFD byte 0xD5, as seen one symbol at a time LSB-first
  localparam logic [1:0] RMII_PRE_SYM = 2'b01;
  localparam logic [1:0] RMII_SFD_SYM = 2'b11;
  localparam logic [3:0] MII_PRE_SYM  = 4'h5;
  localparam logic [3:0] MII_SFD_SYM  = 4'hD;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Bit reversal, used to turn the normal-form polynomial into the reflected
  // form needed by the LSB-first shift
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [3:0] pre_sym(input int phy_w);
    return (phy_w == 4) ? MII_PRE_SYM : {2'b00, RMII_PRE_SYM};
  endfunction

  function automatic logic [3:0] sfd_sym(input int phy_w);
    return (phy_w == 4) ? MII_SFD_SYM : {2'b00, RMII_SFD_SYM};
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte
//   Combinational one-byte step of the reflected Ethernet CRC-32.
//   Ports:
//     crc      in  32  current CRC register
//     data     in  8   byte to absorb (LSB is the first bit on the wire)
//     crc_next out 32  CRC register after absorbing data
module eth_crc32_byte
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] c;

  // Eight unrolled shift/XOR steps; the byte is folded into the low bits up
  // front because the reflected register consumes bit 0 first.
  always_comb begin
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/eth_rx_framer.sv
// eth_rx_framer
//   Receive framer from RMII/MII PHY symbols to a byte stream. Strips the
//   preamble/SFD, assembles bytes LSB-first, checks CRC-32, hides the 4-byte
//   FCS behind a 5-entry delay line and flags the last byte of each frame.
//   Ports:
//     pll_clk        in  1      clock
//     rst_n          in  1      asynchronous active-low reset
//     rx_en          in  1      symbol sample strobe; nothing advances without it
//     phy_rxd        in  PHY_W  receive symbol, LSB-first
//     phy_crs_dv     in  1      carrier sense / data valid
//     m_data         out 8      payload byte
//     m_valid        out 1      one-cycle byte strobe
//     m_last         out 1      last byte of frame (with m_valid)
//     m_err          out 1      frame error (with m_valid && m_last)
//     stat_ok        out 1      one-cycle pulse per good frame
//     stat_bad       out 1      one-cycle pulse per bad/dropped frame
//     stat_drop_cnt  out 16     saturating count of stat_bad pulses
//   PHY_W must be 2 (RMII) or 4 (MII).
module eth_rx_framer
  import eth_rx_pkg::*;
#(
  parameter int PHY_W     = 2,
  parameter int MIN_PRE   = 8,
  parameter int MAX_FRAME = 1518,
  parameter int MIN_FRAME = 64
) (
  input  logic             pll_clk,
  input  logic             rst_n,
  input  logic             rx_en,
  input  logic [PHY_W-1:0] phy_rxd,
  input  logic             phy_crs_dv,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             m_err,
  output logic             stat_ok,
  output logic             stat_bad,
  output logic [15:0]      stat_drop_cnt
);

  localparam int CW  = $clog2(MAX_FRAME + 2);
  localparam int SPB = 8 / PHY_W;

  localparam logic [PHY_W-1:0] PRE_SYM   = PHY_W'(pre_sym(PHY_W));
  localparam logic [PHY_W-1:0] SFD_SYM   = PHY_W'(sfd_sym(PHY_W));
  localparam logic [1:0]       SYM_LAST  = 2'(SPB - 1);
  localparam logic [7:0]       MIN_PRE_C = 8'(MIN_PRE);
  localparam logic [CW-1:0]    MAX_B     = CW'(MAX_FRAME);
  localparam logic [CW-1:0]    MIN_B     = CW'(MIN_FRAME);
  localparam logic [CW-1:0]    DL_FULL   = CW'(5);

  rx_state_t       state, state_nxt;
  logic [7:0]      pre_cnt;
  logic [1:0]      sym_cnt;
  logic [7:0]      shift_reg;
  logic [CW-1:0]   byte_cnt;
  logic [31:0]     crc;
  logic [31:0]     crc_nxt;
  logic [7:0]      dl [5];

  logic            is_pre, is_sfd, byte_done;
  logic [7:0]      new_byte;
  logic            emit, emit_last, emit_err, ok_nxt, bad_nxt;

  assign is_pre    = (phy_rxd == PRE_SYM);
  assign is_sfd    = (phy_rxd == SFD_SYM);
  // New symbols enter at the top so the first one received ends up in bit 0
  assign new_byte  = {phy_rxd, shift_reg[7:PHY_W]};
  assign byte_done = (state == DATA) && rx_en && phy_crs_dv && (sym_cnt == SYM_LAST);

  eth_crc32_byte u_crc (
    .crc      (crc),
    .data     (new_byte),
    .crc_next (crc_nxt)
  );

  // State register
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the emit/status decisions for this sample. dl[4] is the
  // oldest delay-line entry whenever byte_cnt >= 5.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_err  = 1'b0;
    ok_nxt    = 1'b0;
    bad_nxt   = 1'b0;
    if (rx_en) begin
      unique case (state)
        IDLE: begin
          if (phy_crs_dv && is_pre) state_nxt = PRE;
        end
        PRE: begin
          if (!phy_crs_dv) begin
            state_nxt = IDLE;
          end else if (is_sfd && (pre_cnt >= MIN_PRE_C)) begin
            state_nxt = DATA;
          end else if (!is_pre) begin
            state_nxt = DROP;
          end
        end
        DATA: begin
          if (!phy_crs_dv) begin
            state_nxt = IDLE;
            if (byte_cnt >= DL_FULL) begin
              emit      = 1'b1;
              emit_last = 1'b1;
              emit_err  = (crc != CRC_RESIDUE) || (byte_cnt < MIN_B) || (sym_cnt != 2'd0);
              ok_nxt    = !emit_err;
              bad_nxt   = emit_err;
            end else begin
              bad_nxt = 1'b1;
            end
          end else if (byte_done) begin
            // Byte MAX_FRAME+1 is arriving: close the stream now so the
            // counter can never wrap.
            if (byte_cnt == MAX_B) begin
              emit      = 1'b1;
              emit_last = 1'b1;
              emit_err  = 1'b1;
              bad_nxt   = 1'b1;
              state_nxt = DROP;
            end else if (byte_cnt >= DL_FULL) begin
              emit = 1'b1;
            end
          end
        end
        DROP: begin
          if (!phy_crs_dv) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: preamble count, byte assembly, CRC, delay line and registered
  // outputs. Per-frame registers are re-armed whenever we are outside DATA.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt       <= 8'd0;
      sym_cnt       <= 2'd0;
      shift_reg     <= 8'd0;
      byte_cnt      <= '0;
      crc           <= CRC_INIT;
      for (int i = 0; i < 5; i++) dl[i] <= 8'd0;
      m_data        <= 8'd0;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
      m_err         <= 1'b0;
      stat_ok       <= 1'b0;
      stat_bad      <= 1'b0;
      stat_drop_cnt <= 16'd0;
    end else begin
      m_valid  <= emit;
      m_last   <= emit_last;
      m_err    <= emit_err;
      stat_ok  <= ok_nxt;
      stat_bad <= bad_nxt;
      if (emit) m_data <= dl[4];
      if (bad_nxt && (stat_drop_cnt != 16'hFFFF)) stat_drop_cnt <= stat_drop_cnt + 16'd1;

      if (state != DATA) begin
        sym_cnt   <= 2'd0;
        shift_reg <= 8'd0;
        byte_cnt  <= '0;
        crc       <= CRC_INIT;
      end

      if (rx_en) begin
        if (state == IDLE) begin
          pre_cnt <= 8'd1;
        end else if (state == PRE) begin
          if (is_pre && (pre_cnt != 8'hFF)) pre_cnt <= pre_cnt + 8'd1;
        end else if ((state == DATA) && phy_crs_dv) begin
          shift_reg <= new_byte;
          if (byte_done) begin
            sym_cnt  <= 2'd0;
            crc      <= crc_nxt;
            byte_cnt <= byte_cnt + CW'(1);
            dl[0]    <= new_byte;
            for (int i = 1; i < 5; i++) dl[i] <= dl[i-1];
          end else begin
            sym_cnt <= sym_cnt + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_framer.sv
// tb_eth_rx_framer
//   Self-checking bench for eth_rx_framer. Three instances share the clock,
//   reset and strobe: RMII default (sel 0), RMII with MAX_FRAME=100 (sel 1)
//   and MII (sel 2). Carrier is routed only to the selected instance, and the
//   selected instance's byte stream is compared against a scoreboard queue.
module tb_eth_rx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_en;
  logic       crs_dv;
  logic [3:0] sym;
  int         sel;

  logic       crs_a, crs_b, crs_c;
  logic [1:0] rxd2;
  logic [3:0] rxd4;

  logic [7:0]  o_data  [3];
  logic        o_valid [3];
  logic        o_last  [3];
  logic        o_err   [3];
  logic        o_ok    [3];
  logic        o_bad   [3];
  logic [15:0] o_drop  [3];

  assign crs_a = crs_dv && (sel == 0);
  assign crs_b = crs_dv && (sel == 1);
  assign crs_c = crs_dv && (sel == 2);
  assign rxd2  = (sel != 2) ? sym[1:0] : 2'b00;
  assign rxd4  = (sel == 2) ? sym : 4'h0;

  eth_rx_framer #(.PHY_W(2), .MIN_PRE(8), .MAX_FRAME(1518), .MIN_FRAME(64)) u_rmii (
    .pll_clk(clk), .rst_n(rst_n), .rx_en(rx_en), .phy_rxd(rxd2), .phy_crs_dv(crs_a),
    .m_data(o_data[0]), .m_valid(o_valid[0]), .m_last(o_last[0]), .m_err(o_err[0]),
    .stat_ok(o_ok[0]), .stat_bad(o_bad[0]), .stat_drop_cnt(o_drop[0]));

  eth_rx_framer #(.PHY_W(2), .MIN_PRE(8), .MAX_FRAME(100), .MIN_FRAME(64)) u_small (
    .pll_clk(clk), .rst_n(rst_n), .rx_en(rx_en), .phy_rxd(rxd2), .phy_crs_dv(crs_b),
    .m_data(o_data[1]), .m_valid(o_valid[1]), .m_last(o_last[1]), .m_err(o_err[1]),
    .stat_ok(o_ok[1]), .stat_bad(o_bad[1]), .stat_drop_cnt(o_drop[1]));

  eth_rx_framer #(.PHY_W(4), .MIN_PRE(8), .MAX_FRAME(1518), .MIN_FRAME(64)) u_mii (
    .pll_clk(clk), .rst_n(rst_n), .rx_en(rx_en), .phy_rxd(rxd4), .phy_crs_dv(crs_c),
    .m_data(o_data[2]), .m_valid(o_valid[2]), .m_last(o_last[2]), .m_err(o_err[2]),
    .stat_ok(o_ok[2]), .stat_bad(o_bad[2]), .stat_drop_cnt(o_drop[2]));

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       err;
  } exp_t;

  typedef struct {
    string name;
    int    sel;
    int    len;
    int    flip;
    int    extra;
    int    div;
    int    exp_bytes;
    bit    exp_err;
    int    exp_ok;
    int    exp_bad;
  } tv_t;

  exp_t       sb [$];
  logic [7:0] frame [$];
  tv_t        tbl [8];
  int         checks;
  int         errors;
  int         ok_seen;
  int         bad_seen;
  int         exp_drop [3];

  // Payload pattern depends only on byte index, so every frame of a given
  // length carries the same bytes whichever PHY width delivers it.
  task automatic build_frame(input int len, input int flip);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    frame.delete();
    if (len < 5) begin
      for (int i = 0; i < len; i++) frame.push_back(8'(i * 37 + 11));
    end else begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len - 4; i++) begin
        b = 8'(i * 37 + 11);
        frame.push_back(b);
        for (int j = 0; j < 8; j++) begin
          fb = c[0] ^ b[j];
          c  = c >> 1;
          if (fb) c = c ^ 32'hEDB88320;
        end
      end
      c = ~c;
      for (int k = 0; k < 4; k++) frame.push_back(c[k*8 +: 8]);
    end
    if (flip >= 0) frame[flip / 8] = frame[flip / 8] ^ (8'h01 << (flip % 8));
  endtask

  task automatic send_sym(input logic [3:0] s, input logic dv, input int div);
    sym    = s;
    crs_dv = dv;
    rx_en  = 1'b1;
    @(posedge clk); #1;
    rx_en  = 1'b0;
    for (int i = 1; i < div; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input int s, input int pre_syms, input int nbytes,
                               input int extra, input int div, input bit do_end);
    int         w;
    logic [7:0] b;
    logic [3:0] v;
    sel = s;
    w   = (s == 2) ? 4 : 2;
    for (int i = 0; i < pre_syms; i++) send_sym((w == 4) ? 4'h5 : 4'h1, 1'b1, div);
    send_sym((w == 4) ? 4'hD : 4'h3, 1'b1, div);
    for (int i = 0; i < nbytes; i++) begin
      b = frame[i];
      for (int k = 0; k < 8 / w; k++) begin
        v = (w == 4) ? b[k*4 +: 4] : {2'b00, b[k*2 +: 2]};
        send_sym(v, 1'b1, div);
      end
    end
    for (int i = 0; i < extra; i++) send_sym(4'h2, 1'b1, div);
    if (do_end) begin
      for (int i = 0; i < 4; i++) send_sym(4'h0, 1'b0, div);
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input int s, input int eok, input int ebad);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_pending: got %0d bytes still expected, required 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (ok_seen != eok) begin
      errors++;
      $display("[TB] FAIL %s_stat_ok: got %0d pulses, required %0d", name, ok_seen, eok);
    end
    checks++;
    if (bad_seen != ebad) begin
      errors++;
      $display("[TB] FAIL %s_stat_bad: got %0d pulses, required %0d", name, bad_seen, ebad);
    end
    checks++;
    if (o_drop[s] !== 16'(exp_drop[s])) begin
      errors++;
      $display("[TB] FAIL %s_drop_cnt: got %0d, required %0d", name, o_drop[s], exp_drop[s]);
    end
  endtask

  task automatic run_case(input tv_t t);
    exp_t e;
    build_frame(t.len, t.flip);
    for (int i = 0; i < t.exp_bytes; i++) begin
      e.data = frame[i];
      e.last = (i == t.exp_bytes - 1);
      e.err  = e.last ? t.exp_err : 1'b0;
      sb.push_back(e);
    end
    ok_seen  = 0;
    bad_seen = 0;
    exp_drop[t.sel] += t.exp_bad;
    applyStimulus(t.sel, (t.sel == 2) ? 15 : 31, t.len, t.extra, t.div, 1'b1);
    checkOutput(t.name, t.sel, t.exp_ok, t.exp_bad);
  endtask

  // Watches the selected instance on the falling edge, away from the
  // registering edge, and pops one expected byte per strobe.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_valid[sel]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_byte: got data=%02h last=%0b err=%0b, required no byte",
                     o_data[sel], o_last[sel], o_err[sel]);
          end else begin
            e = sb.pop_front();
            if (o_data[sel] !== e.data || o_last[sel] !== e.last || (e.last && o_err[sel] !== e.err)) begin
              errors++;
              $display("[TB] FAIL byte: got data=%02h last=%0b err=%0b, required data=%02h last=%0b err=%0b",
                       o_data[sel], o_last[sel], o_err[sel], e.data, e.last, e.err);
            end
          end
          if (o_last[sel]) begin
            checks++;
            if ((o_ok[sel] ^ o_bad[sel]) !== 1'b1 || o_ok[sel] !== !o_err[sel]) begin
              errors++;
              $display("[TB] FAIL stat_with_last: got ok=%0b bad=%0b err=%0b, required one pulse matching err",
                       o_ok[sel], o_bad[sel], o_err[sel]);
            end
          end
        end
        if (o_ok[sel]) ok_seen++;
        if (o_bad[sel]) bad_seen++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ok_seen  = 0;
    bad_seen = 0;
    for (int i = 0; i < 3; i++) exp_drop[i] = 0;
    rst_n  = 1'b0;
    rx_en  = 1'b0;
    crs_dv = 1'b0;
    sym    = 4'h0;
    sel    = 0;

    tbl[0] = '{"good_rmii",  0,  64,  -1, 0, 1, 60, 1'b0, 1, 0};
    tbl[1] = '{"bitflip",    0,  64, 100, 0, 1, 60, 1'b1, 0, 1};
    tbl[2] = '{"runt40",     0,  40,  -1, 0, 1, 36, 1'b1, 0, 1};
    tbl[3] = '{"burst3",     0,   3,  -1, 0, 1,  0, 1'b0, 0, 1};
    tbl[4] = '{"oversize",   1, 120,  -1, 0, 1, 96, 1'b1, 0, 1};
    tbl[5] = '{"good_mii",   2,  64,  -1, 0, 2, 60, 1'b0, 1, 0};
    tbl[6] = '{"align_err",  0,  64,  -1, 1, 1, 60, 1'b1, 0, 1};
    tbl[7] = '{"small_good", 1,  64,  -1, 0, 1, 60, 1'b0, 1, 0};

    #12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_data[i], o_valid[i], o_last[i], o_err[i], o_ok[i], o_bad[i], o_drop[i]} !== 30'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs[%0d]: got data=%02h v=%0b l=%0b e=%0b ok=%0b bad=%0b drop=%0d, required all 0",
                 i, o_data[i], o_valid[i], o_last[i], o_err[i], o_ok[i], o_bad[i], o_drop[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    fork
      monitor_loop();
    join_none

    for (int i = 0; i < 8; i++) run_case(tbl[i]);

    // Four preamble symbols before the SFD are too few: the frame is dropped
    build_frame(64, -1);
    ok_seen  = 0;
    bad_seen = 0;
    sel      = 0;
    applyStimulus(0, 4, 20, 0, 1, 1'b0);
    checks++;
    if (ok_seen != 0 || bad_seen != 0) begin
      errors++;
      $display("[TB] FAIL short_pre_status: got ok=%0d bad=%0d, required 0 and 0", ok_seen, bad_seen);
    end
    checks++;
    if (o_drop[0] !== 16'(exp_drop[0])) begin
      errors++;
      $display("[TB] FAIL short_pre_drop_cnt: got %0d, required %0d", o_drop[0], exp_drop[0]);
    end
    for (int i = 0; i < 4; i++) send_sym(4'h0, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-payload: 20 bytes in, 15 emitted, then no last for this frame
    begin
      exp_t e;
      build_frame(64, -1);
      for (int i = 0; i < 15; i++) begin
        e.data = frame[i];
        e.last = 1'b0;
        e.err  = 1'b0;
        sb.push_back(e);
      end
    end
    ok_seen  = 0;
    bad_seen = 0;
    applyStimulus(0, 31, 20, 0, 1, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({o_data[0], o_valid[0], o_last[0], o_err[0], o_ok[0], o_bad[0], o_drop[0]} !== 30'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got data=%02h v=%0b l=%0b e=%0b ok=%0b bad=%0b drop=%0d, required all 0",
               o_data[0], o_valid[0], o_last[0], o_err[0], o_ok[0], o_bad[0], o_drop[0]);
    end
    crs_dv = 1'b0;
    sym    = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_drop[i] = 0;
    for (int i = 0; i < 4; i++) send_sym(4'h0, 1'b0, 1);
    checkOutput("reset_abort", 0, 0, 0);
    run_case(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
